// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the programmable multi-pattern sequence detector.
// Channel config is held at the widest supported size; lanes mask down to the active length.
package seqdet_pkg;

    localparam int MAX_LEN_LIMIT = 32;
    localparam int N_PAT_LIMIT   = 8;
    localparam int CFG_LEN_W     = $clog2(MAX_LEN_LIMIT + 1);

    typedef struct packed {
        logic [MAX_LEN_LIMIT-1:0] pattern;
        logic [CFG_LEN_W-1:0]     len;
        logic                     overlap;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{pattern: '0, len: '0, overlap: 1'b1};

    function automatic logic len_valid(input logic [CFG_LEN_W-1:0] len, input int max_len);
        return (len != '0) && (int'(len) <= max_len);
    endfunction

    // Ones in the low len bits; lengths of the full width yield an all-ones mask.
    function automatic logic [MAX_LEN_LIMIT-1:0] len_mask(input logic [CFG_LEN_W-1:0] len);
        return (int'(len) >= MAX_LEN_LIMIT) ? '1
             : (MAX_LEN_LIMIT'(1) << len) - MAX_LEN_LIMIT'(1);
    endfunction

endpackage

// File: rtl/seq_match_lane.sv
// One detector channel: config registers, fill counter, masked comparator and saturating hit counter.
// The comparison window is the shared history with the current bit in position 0.
module seq_match_lane
    import seqdet_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               din_valid_i,
    input  logic [MAX_LEN-1:0] window_i,
    input  logic               cfg_load_i,
    input  cfg_t               cfg_wr_i,
    output logic               match_o,
    output logic [CNT_W-1:0]   hit_cnt_o
);

    cfg_t             cfg_q, cfg_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MAX_LEN_LIMIT-1:0] window_ext;
    logic             len_ok, fill_ok, bits_ok;

    // Fill gating guarantees only bits received since the last clear take part in a match.
    always_comb begin
        window_ext = MAX_LEN_LIMIT'(window_i);
        len_ok     = len_valid(cfg_q.len, MAX_LEN);
        fill_ok    = (int'(fill_q) + 1) >= int'(cfg_q.len);
        bits_ok    = ((window_ext ^ cfg_q.pattern) & len_mask(cfg_q.len)) == '0;
        match_o    = din_valid_i && len_ok && fill_ok && bits_ok;
    end

    always_comb begin
        cfg_d  = cfg_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        if (din_valid_i) begin
            if (match_o && !cfg_q.overlap) begin
                fill_d = '0;
            end else if (int'(fill_q) < MAX_LEN) begin
                fill_d = fill_q + 1'b1;
            end
            if (match_o && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // A config write overrides whatever the stream did to this lane in the same cycle.
        if (cfg_load_i) begin
            cfg_d  = cfg_wr_i;
            fill_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q  <= CFG_RESET;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            cfg_q  <= cfg_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

    assign hit_cnt_o = cnt_q;

endmodule

// File: rtl/multi_seq_detector.sv
// Runtime-programmable N-channel Mealy sequence detector on a valid-qualified serial stream.
// Holds the shared bit history and config write decode; each channel is a seq_match_lane.
module multi_seq_detector
    import seqdet_pkg::*;
#(
    parameter int N_PAT   = 2,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int IDX_W   = (N_PAT > 1) ? $clog2(N_PAT) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic [N_PAT-1:0]   match,
    output logic               any_match,
    output logic [N_PAT*CNT_W-1:0] hit_cnt
);

    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] window;
    cfg_t               cfg_wr;

    assign window = {hist_q, din};
    assign hist_d = window[MAX_LEN-2:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
        end else if (din_valid) begin
            hist_q <= hist_d;
        end
    end

    always_comb begin
        cfg_wr.pattern = MAX_LEN_LIMIT'(cfg_pattern);
        cfg_wr.len     = CFG_LEN_W'(cfg_len);
        cfg_wr.overlap = cfg_overlap;
    end

    // Out-of-range indices never equal a lane number, so such writes are dropped.
    for (genvar i = 0; i < N_PAT; i++) begin : g_lane
        logic load;
        assign load = cfg_we && (cfg_idx == IDX_W'(i));

        seq_match_lane #(
            .MAX_LEN (MAX_LEN),
            .CNT_W   (CNT_W),
            .LEN_W   (LEN_W)
        ) u_lane (
            .clk         (clk),
            .reset_n     (reset_n),
            .din_valid_i (din_valid),
            .window_i    (window),
            .cfg_load_i  (load),
            .cfg_wr_i    (cfg_wr),
            .match_o     (match[i]),
            .hit_cnt_o   (hit_cnt[i*CNT_W +: CNT_W])
        );
    end

    assign any_match = |match;

endmodule
